voter_ballot_collector: RTL and testbench
=========================================

Name: voter_ballot_collector

Overview:
- Front end of the four-voter decision path. Collects individual ballots serially over a valid/ready interface during a bounded voting session.
- Assembles the 4-bit vote vector consumed by the combinational voter (bit i = voter i; 1 = approve, 0 = reject).
- Presents that vector with a valid/ready handshake so downstream logic latches one complete, stable vector per session.
- Handles duplicate ballots and absentee timeout.

Parameters:
- NUM_VOTERS, 4, number of voters. Fixed at 4 in this revision; ID width is 2.
- TIMEOUT_CYCLES, 16, maximum COLLECT cycles per session (legal range 1..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to open a session; honoured only in IDLE
- vote_valid  input  1  ballot offered this cycle
- vote_id  input  2  voter index 0..3
- vote_val  input  1  ballot value, 1 = approve
- vote_ready  output  1  ballot accepted when vote_valid && vote_ready
- ballot  output  4  assembled vote vector; bit i = voter i
- ballot_valid  output  1  ballot is complete and stable
- ballot_ready  input  1  consumer accepts the ballot
- voted_mask  output  4  bit i set once voter i has been accepted this session
- timed_out  output  1  session closed by timeout; valid while ballot_valid = 1
- dup_err  output  1  one-cycle pulse when a repeat ballot is rejected
- busy  output  1  high in COLLECT or PRESENT

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; ballot, voted_mask, timer = 0; all outputs 0. Reset mid-session discards the session entirely.
- States: IDLE, COLLECT, PRESENT. All outputs are registered except vote_ready, which equals (state == COLLECT).
- IDLE:
  - start = 1 -> COLLECT next cycle.
  - On entry to COLLECT: ballot = 0, voted_mask = 0, timer = 0, timed_out = 0.
  - vote_valid in IDLE is ignored.
- COLLECT:
  - Accepted vote with voted_mask[vote_id] = 0: ballot[vote_id] <= vote_val and voted_mask[vote_id] <= 1.
  - Accepted vote with voted_mask[vote_id] = 1: the ballot is dropped, the original value is retained, and dup_err pulses high on the next cycle.
  - Timer increments every COLLECT cycle.
  - Exit when voted_mask becomes 4'b1111 (including the cycle the fourth vote lands) -> PRESENT next cycle with timed_out = 0.
  - Otherwise exit when timer == TIMEOUT_CYCLES-1 -> PRESENT. A vote arriving on that cycle is still accepted. If this completes the mask, timed_out = 0; if not, timed_out = 1 and missing voters' bits stay 0 (absentee counts as reject).
  - start during COLLECT is ignored.
- PRESENT:
  - ballot_valid = 1; ballot, voted_mask and timed_out are held stable.
  - vote_ready = 0; start is ignored.
  - ballot_valid && ballot_ready -> IDLE next cycle; ballot_valid drops that cycle. ballot and voted_mask keep their values until the next session opens.
- Latency:
  - start at cycle N -> vote_ready = 1 at N+1.
  - Fourth unique vote accepted at cycle M -> ballot_valid = 1 at M+1.
  - Minimum session is start + 4 vote cycles + 1 present cycle.
- busy = (state != IDLE).

Test Plan:
- Reset, then start; votes id0=1, id1=1, id2=1, id3=0 on consecutive cycles -> ballot_valid one cycle after the id3 vote, ballot = 4'b0111, voted_mask = 4'b1111, timed_out = 0. ballot_ready = 1 -> IDLE and busy = 0 next cycle.
- Votes in order id3=1, id0=0, id2=1, id1=0 with idle gaps -> ballot = 4'b1100, ballot_valid held for 5 cycles while ballot_ready = 0, ballot unchanged throughout.
- id1=1, then id1=0 repeated -> dup_err pulses once; id0=0, id2=0, id3=0 -> ballot = 4'b0010.
- Only id0=1 and id2=1 arrive, TIMEOUT_CYCLES = 16 -> PRESENT exactly 16 cycles after entering COLLECT, ballot = 4'b0101, voted_mask = 4'b0101, timed_out = 1.
- Fourth vote arrives on the final timeout cycle -> ballot = 4'b1111, timed_out = 0. start pulsed during PRESENT is ignored, and vote_valid in IDLE is not accepted.
- rst_n asserted after two votes -> all outputs 0 immediately; a new start gives an empty voted_mask and ballot = 0.

Source files
------------

// File: rtl/voter_ballot_collector.sv
// Collects serial voter ballots during a bounded session and presents the
// assembled 4-bit vote vector to the downstream voter over valid/ready.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               open a session (honoured only when idle)
//   vote_valid/ready    ballot handshake; vote_id selects the voter, vote_val = approve
//   ballot              assembled vote vector, bit i = voter i
//   ballot_valid/ready  presentation handshake towards the consumer
//   voted_mask          voters accepted in the current/last session
//   timed_out           session closed with absentees (valid with ballot_valid)
//   dup_err             one-cycle pulse after a repeat ballot is dropped
//   busy                session in progress (collecting or presenting)
module voter_ballot_collector #(
  parameter int unsigned NUM_VOTERS     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  vote_valid,
  input  logic [1:0]            vote_id,
  input  logic                  vote_val,
  output logic                  vote_ready,
  output logic [NUM_VOTERS-1:0] ballot,
  output logic                  ballot_valid,
  input  logic                  ballot_ready,
  output logic [NUM_VOTERS-1:0] voted_mask,
  output logic                  timed_out,
  output logic                  dup_err,
  output logic                  busy
);

  localparam int unsigned TimerW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [TimerW-1:0]     timer, timer_d;
  logic [NUM_VOTERS-1:0] ballot_d, mask_d, mask_set, mask_upd;
  logic                  timed_out_d, dup_d;
  logic                  accept, is_dup, all_in, last_cycle;

  // Ballot decode: a first-time ballot sets its mask bit, a repeat is flagged.
  always_comb begin
    accept     = vote_valid && (state == COLLECT);
    is_dup     = accept && voted_mask[vote_id];
    mask_set   = '0;
    if (accept && !voted_mask[vote_id]) begin
      mask_set[vote_id] = 1'b1;
    end
    mask_upd   = voted_mask | mask_set;
    all_in     = &mask_upd;
    last_cycle = (timer == TimerW'(TIMEOUT_CYCLES - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a completed mask wins over the timeout on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (all_in || last_cycle) state_next = PRESENT;
      PRESENT: if (ballot_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    vote_ready  = 1'b0;
    ballot_d    = ballot;
    mask_d      = voted_mask;
    timer_d     = timer;
    timed_out_d = timed_out;
    dup_d       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          ballot_d    = '0;
          mask_d      = '0;
          timer_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      COLLECT: begin
        vote_ready = 1'b1;
        timer_d    = timer + TimerW'(1);
        if (|mask_set) begin
          ballot_d[vote_id] = vote_val;
        end
        mask_d = mask_upd;
        dup_d  = is_dup;
        // Absentees keep their reset-to-zero bit, i.e. count as reject.
        if (last_cycle && !all_in) begin
          timed_out_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ballot       <= '0;
      voted_mask   <= '0;
      timer        <= '0;
      timed_out    <= 1'b0;
      dup_err      <= 1'b0;
      ballot_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ballot       <= ballot_d;
      voted_mask   <= mask_d;
      timer        <= timer_d;
      timed_out    <= timed_out_d;
      dup_err      <= dup_d;
      ballot_valid <= (state_next == PRESENT);
      busy         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_voter_ballot_collector.sv
// Scoreboard bench for voter_ballot_collector: stimulus pushes the expected
// presented vector, a negedge monitor compares it every presented cycle.
module tb_voter_ballot_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vote_valid = 1'b0;
  logic [1:0] vote_id = 2'd0;
  logic       vote_val = 1'b0;
  logic       vote_ready;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic       ballot_ready = 1'b0;
  logic [3:0] voted_mask;
  logic       timed_out;
  logic       dup_err;
  logic       busy;

  int compared = 0;
  int mismatched = 0;
  int dup_cnt = 0;

  typedef struct {
    logic [3:0] b;
    logic [3:0] m;
    logic       t;
  } exp_t;

  exp_t exp_q[$];

  voter_ballot_collector #(.NUM_VOTERS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vote_valid(vote_valid), .vote_id(vote_id), .vote_val(vote_val),
    .vote_ready(vote_ready), .ballot(ballot), .ballot_valid(ballot_valid),
    .ballot_ready(ballot_ready), .voted_mask(voted_mask),
    .timed_out(timed_out), .dup_err(dup_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every presented cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (dup_err === 1'b1) dup_cnt++;
    if (ballot_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_present: ballot %0h with empty scoreboard at %0t", ballot, $time);
      end else begin
        chk("ballot", 32'(ballot), 32'(exp_q[0].b));
        chk("voted_mask", 32'(voted_mask), 32'(exp_q[0].m));
        chk("timed_out", 32'(timed_out), 32'(exp_q[0].t));
        if (ballot_ready) exp_q.pop_front();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic open_session();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic vote(int id, bit v);
    vote_valid = 1'b1;
    vote_id    = 2'(id);
    vote_val   = v;
    step();
    vote_valid = 1'b0;
  endtask

  task automatic release_ballot();
    ballot_ready = 1'b1;
    step();
    ballot_ready = 1'b0;
  endtask

  task automatic expect_push(logic [3:0] b, logic [3:0] m, logic t);
    exp_t e;
    e.b = b; e.m = m; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_vote_ready"}, 32'(vote_ready), 0);
    chk({tag, "_ballot"}, 32'(ballot), 0);
    chk({tag, "_ballot_valid"}, 32'(ballot_valid), 0);
    chk({tag, "_voted_mask"}, 32'(voted_mask), 0);
    chk({tag, "_timed_out"}, 32'(timed_out), 0);
    chk({tag, "_dup_err"}, 32'(dup_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Session 1: consecutive votes, 4'b0111
    expect_push(4'b0111, 4'b1111, 1'b0);
    open_session();
    chk("s1_vote_ready_latency", 32'(vote_ready), 1);
    chk("s1_busy", 32'(busy), 1);
    vote(0, 1); vote(1, 1); vote(2, 1);
    chk("s1_not_yet_valid", 32'(ballot_valid), 0);
    vote(3, 0);
    chk("s1_valid_latency", 32'(ballot_valid), 1);
    chk("s1_vote_ready_present", 32'(vote_ready), 0);
    release_ballot();
    chk("s1_busy_after", 32'(busy), 0);
    chk("s1_valid_after", 32'(ballot_valid), 0);

    // Session 2: out of order with gaps, held 5+ cycles -> 4'b1100
    expect_push(4'b1100, 4'b1111, 1'b0);
    open_session();
    vote(3, 1); idle(1);
    vote(0, 0); idle(2);
    vote(2, 1); idle(1);
    vote(1, 0);
    chk("s2_valid", 32'(ballot_valid), 1);
    idle(5);
    chk("s2_still_valid", 32'(ballot_valid), 1);
    release_ballot();

    // Session 3: duplicate ballot dropped -> 4'b0010
    expect_push(4'b0010, 4'b1111, 1'b0);
    open_session();
    vote(1, 1);
    vote(1, 0);
    chk("s3_dup_pulse", 32'(dup_err), 1);
    vote(0, 0);
    chk("s3_dup_cleared", 32'(dup_err), 0);
    vote(2, 0);
    vote(3, 0);
    chk("s3_valid", 32'(ballot_valid), 1);
    release_ballot();

    // Session 4: timeout with only id0, id2 -> present 16 cycles after entry
    expect_push(4'b0101, 4'b0101, 1'b1);
    open_session();
    vote(0, 1);
    vote(2, 1);
    idle(13);
    chk("s4_valid_before_timeout", 32'(ballot_valid), 0);
    chk("s4_busy_collect", 32'(busy), 1);
    step();
    chk("s4_valid_at_timeout", 32'(ballot_valid), 1);
    release_ballot();

    // Votes offered in IDLE are not accepted
    chk("idle_vote_ready", 32'(vote_ready), 0);
    vote(1, 1);
    chk("idle_mask_held", 32'(voted_mask), 32'h5);
    chk("idle_ballot_held", 32'(ballot), 32'h5);

    // Session 5: fourth vote on the final timeout cycle; start in PRESENT ignored
    expect_push(4'b1111, 4'b1111, 1'b0);
    open_session();
    vote(0, 1); vote(1, 1); vote(2, 1);
    idle(12);
    chk("s5_valid_before_last", 32'(ballot_valid), 0);
    vote(3, 1);
    chk("s5_valid", 32'(ballot_valid), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("s5_start_ignored_valid", 32'(ballot_valid), 1);
    chk("s5_start_ignored_ready", 32'(vote_ready), 0);
    idle(1);
    release_ballot();
    chk("s5_busy_after", 32'(busy), 0);

    // Session 6: reset mid-session discards it
    open_session();
    vote(0, 1);
    vote(1, 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    #1 rst_n = 1'b1;
    step();
    expect_push(4'b1010, 4'b1111, 1'b0);
    open_session();
    chk("s6_mask_empty", 32'(voted_mask), 0);
    chk("s6_ballot_empty", 32'(ballot), 0);
    chk("s6_vote_ready", 32'(vote_ready), 1);
    vote(0, 0); vote(1, 1); vote(2, 0); vote(3, 1);
    chk("s6_valid", 32'(ballot_valid), 1);
    release_ballot();

    idle(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("dup_pulse_count", 32'(dup_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
